// File: rtl/piano_poly_tone.sv
// Polyphonic-key piano buzzer: debounced active-low keys, lowest-index priority,
// runtime octave shift and optional sustain, driving a square wave on `out`.
module piano_poly_tone #(
  parameter int                        N_KEYS       = 4,
  parameter int                        IDX_W        = 2,
  parameter int                        DIV_W        = 17,
  parameter logic [N_KEYS*DIV_W-1:0]   TONE_DIV     = {17'd71633, 17'd75758, 17'd85034, 17'd95420},
  parameter int                        DEBOUNCE_CYC = 1_000_000,
  parameter int                        SUSTAIN_CYC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys,
  input  logic [1:0]        oct_shift,
  output logic              out,
  output logic              note_valid,
  output logic [IDX_W-1:0]  note_idx
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int SU_W = (SUSTAIN_CYC > 1) ? $clog2(SUSTAIN_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [SU_W-1:0] SUS_LAST = SU_W'((SUSTAIN_CYC > 0) ? SUSTAIN_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    SUSTAIN
  } state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] key_db;
  logic [DB_W-1:0]   db_cnt [N_KEYS];

  logic [IDX_W-1:0]  sel;
  logic              any;

  state_t            state_q, state_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [DIV_W:0]    tone_cnt, cnt_nxt;
  logic [DIV_W:0]    half_q, half_nxt;
  logic [SU_W-1:0]   sus_cnt, sus_nxt;
  logic              out_nxt;

  logic              wrap;
  logic [DIV_W:0]    tick_cnt;
  logic              tick_out;
  logic [DIV_W:0]    tick_half;
  logic [DIV_W:0]    half_sel;

  // Half-period for a key under an octave shift; the down-shift widens by one bit so it cannot overflow.
  function automatic logic [DIV_W:0] half_of(input logic [IDX_W-1:0] idx, input logic [1:0] oct);
    logic [DIV_W-1:0] base;
    logic [DIV_W:0]   h;
    base = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (idx == IDX_W'(i)) base = TONE_DIV[i*DIV_W +: DIV_W];
    end
    case (oct)
      2'd0:    h = {1'b0, base};
      2'd1:    h = {2'b0, base[DIV_W-1:1]};
      2'd2:    h = {3'b0, base[DIV_W-1:2]};
      default: h = {base, 1'b0};
    endcase
    if (h == '0) h = {{DIV_W{1'b0}}, 1'b1};
    return h;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      key_db <= '1;
      for (int unsigned i = 0; i < N_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (sync2[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          key_db[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (!key_db[i] && !any) begin
        sel = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

  // Octave changes take effect only at a wrap, so a period in flight is never cut short.
  always_comb begin
    half_sel  = half_of(sel, oct_shift);
    wrap      = (tone_cnt == half_q - 1'b1);
    tick_cnt  = wrap ? '0 : tone_cnt + 1'b1;
    tick_out  = wrap ? ~out : out;
    tick_half = wrap ? half_of(note_idx, oct_shift) : half_q;
  end

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = note_idx;
    cnt_nxt   = tone_cnt;
    half_nxt  = half_q;
    out_nxt   = out;
    sus_nxt   = sus_cnt;
    case (state_q)
      IDLE: begin
        out_nxt = 1'b0;
        cnt_nxt = '0;
        if (any) begin
          state_nxt = PLAY;
          idx_nxt   = sel;
          half_nxt  = half_sel;
        end
      end
      PLAY: begin
        if (!any) begin
          if (SUSTAIN_CYC > 0) begin
            state_nxt = SUSTAIN;
            sus_nxt   = '0;
            cnt_nxt   = tick_cnt;
            out_nxt   = tick_out;
            half_nxt  = tick_half;
          end else begin
            state_nxt = IDLE;
            out_nxt   = 1'b0;
            cnt_nxt   = '0;
          end
        end else if (sel != note_idx) begin
          idx_nxt  = sel;
          cnt_nxt  = '0;
          half_nxt = half_sel;
        end else begin
          cnt_nxt  = tick_cnt;
          out_nxt  = tick_out;
          half_nxt = tick_half;
        end
      end
      SUSTAIN: begin
        if (any) begin
          state_nxt = PLAY;
          if (sel != note_idx) begin
            idx_nxt  = sel;
            cnt_nxt  = '0;
            half_nxt = half_sel;
          end else begin
            cnt_nxt  = tick_cnt;
            out_nxt  = tick_out;
            half_nxt = tick_half;
          end
        end else if (sus_cnt == SUS_LAST) begin
          state_nxt = IDLE;
          out_nxt   = 1'b0;
          cnt_nxt   = '0;
        end else begin
          sus_nxt  = sus_cnt + 1'b1;
          cnt_nxt  = tick_cnt;
          out_nxt  = tick_out;
          half_nxt = tick_half;
        end
      end
      default: begin
        state_nxt = IDLE;
        out_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      note_idx   <= '0;
      note_valid <= 1'b0;
      tone_cnt   <= '0;
      half_q     <= {{DIV_W{1'b0}}, 1'b1};
      sus_cnt    <= '0;
      out        <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      note_idx   <= idx_nxt;
      note_valid <= (state_nxt != IDLE);
      tone_cnt   <= cnt_nxt;
      half_q     <= half_nxt;
      sus_cnt    <= sus_nxt;
      out        <= out_nxt;
    end
  end

endmodule
